// File: rtl/block_draw_scheduler.sv
// Block-draw request scheduler: buffers draw requests in a small FIFO and replays
// them one at a time into the block drawer, restarting the drawer for each request
// and holding it for a cycle budget that covers the drawer's worst-case sweep.
module block_draw_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    input  logic [3:0] req_size,
    output logic [7:0] start_x,
    output logic [6:0] start_y,
    output logic [2:0] colour,
    output logic [3:0] block_size,
    output logic       drawer_resetn,
    output logic       busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(256 + SETTLE + 1);
    localparam int unsigned EW = 22;

    typedef enum logic [1:0] {StIdle, StRestart, StDraw} state_t;

    state_t          r_state, w_state_next;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PW:0]     r_count;
    logic [CW-1:0]   r_counter, w_counter_next;
    logic [7:0]      r_start_x;
    logic [6:0]      r_start_y;
    logic [2:0]      r_colour;
    logic [3:0]      r_block_size;

    logic            w_full, w_empty, w_push, w_pop, w_latch;
    logic [EW-1:0]   w_head;
    logic [7:0]      w_head_x;
    logic [6:0]      w_head_y;
    logic [2:0]      w_head_c;
    logic [3:0]      w_head_s;
    logic [8:0]      w_sum_x, w_sum_y, w_prod;
    logic [4:0]      w_side;
    logic [7:0]      w_clamp_x;
    logic [6:0]      w_clamp_y;
    logic [CW-1:0]   w_budget_m1;

    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // Refusal on full is independent of a same-cycle pop.
    assign w_push  = req_valid && !w_full;
    assign w_pop   = (r_state == StIdle) && !w_empty;

    assign w_head = r_mem[r_rd_ptr];
    assign {w_head_x, w_head_y, w_head_c, w_head_s} = w_head;
    // Zero-size entries are popped but never latched.
    assign w_latch = w_pop && (w_head_s != 4'd0);

    // Clamp so the whole block lands inside the 160x120 frame.
    assign w_sum_x   = {1'b0, w_head_x} + {5'b0, w_head_s};
    assign w_sum_y   = {2'b0, w_head_y} + {5'b0, w_head_s};
    assign w_clamp_x = (w_sum_x > 9'd160) ? 8'(9'd160 - {5'b0, w_head_s}) : w_head_x;
    assign w_clamp_y = (w_sum_y > 9'd120) ? 7'(9'd120 - {5'b0, w_head_s}) : w_head_y;

    // Draw budget minus one, derived from the already-latched size.
    assign w_side      = {1'b0, r_block_size} + 5'd1;
    assign w_prod      = {4'b0, w_side} * {4'b0, w_side};
    assign w_budget_m1 = CW'(w_prod) + CW'(SETTLE) - CW'(1);

    // FIFO storage; contents need no reset because pointers and occupancy do.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {req_x, req_y, req_colour, req_size};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // State and draw-cycle counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_counter <= '0;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        unique case (r_state)
            StIdle: begin
                if (w_latch) w_state_next = StRestart;
            end
            StRestart: begin
                w_counter_next = w_budget_m1;
                w_state_next   = StDraw;
            end
            StDraw: begin
                if (r_counter == '0) w_state_next = StIdle;
                else                 w_counter_next = r_counter - 1'b1;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output latches hold until the next non-zero-size pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_start_x    <= '0;
            r_start_y    <= '0;
            r_colour     <= '0;
            r_block_size <= '0;
        end else if (w_latch) begin
            r_start_x    <= w_clamp_x;
            r_start_y    <= w_clamp_y;
            r_colour     <= w_head_c;
            r_block_size <= w_head_s;
        end
    end

    assign start_x       = r_start_x;
    assign start_y       = r_start_y;
    assign colour        = r_colour;
    assign block_size    = r_block_size;
    assign drawer_resetn = (r_state == StDraw);
    assign busy          = !w_empty || (r_state != StIdle);
    assign req_ready     = !w_full;

endmodule

// File: tb/tb_block_draw_scheduler.sv
// Bench for block_draw_scheduler: directed scenarios followed by random traffic,
// all checked every cycle against a timeline model of the scheduler.
module tb_block_draw_scheduler;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic [3:0] req_size;
    logic [7:0] start_x;
    logic [6:0] start_y;
    logic [2:0] colour;
    logic [3:0] block_size;
    logic       drawer_resetn;
    logic       busy;

    block_draw_scheduler #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_colour    (req_colour),
        .req_size      (req_size),
        .start_x       (start_x),
        .start_y       (start_y),
        .colour        (colour),
        .block_size    (block_size),
        .drawer_resetn (drawer_resetn),
        .busy          (busy)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: pending requests, plus the cycle window in which the drawer runs
    // and the cycle from which the scheduler is free to pop again.
    typedef struct { int x; int y; int c; int s; } req_t;
    req_t q[$];
    int   cyc;
    int   idle_at;
    int   draw_lo;
    int   draw_hi;
    int   ex, ey, ec, es;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        idle_at = 0;
        draw_lo = 0;
        draw_hi = 0;
        ex = 0; ey = 0; ec = 0; es = 0;
    endtask

    task automatic check_outputs();
        chk("req_ready", req_ready, int'(q.size() < DEPTH));
        chk("busy", busy, int'(q.size() != 0 || cyc < idle_at));
        chk("drawer_resetn", drawer_resetn, int'(cyc >= draw_lo && cyc < draw_hi));
        chk("start_x", start_x, ex);
        chk("start_y", start_y, ey);
        chk("colour", colour, ec);
        chk("block_size", block_size, es);
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit   pop;
        bit   push;
        req_t e;
        if (reset) begin
            model_reset();
        end else begin
            pop  = (cyc >= idle_at) && (q.size() > 0);
            push = req_valid && (q.size() < DEPTH);
            if (pop) begin
                e = q.pop_front();
                if (e.s != 0) begin
                    ex = (e.x + e.s > 160) ? 160 - e.s : e.x;
                    ey = (e.y + e.s > 120) ? 120 - e.s : e.y;
                    ec = e.c;
                    es = e.s;
                    // pop cycle, one restart cycle, then the full budget of draw cycles
                    draw_lo = cyc + 2;
                    draw_hi = cyc + 2 + (e.s + 1) * (e.s + 1) + SETTLE;
                    idle_at = draw_hi;
                end
            end
            if (push) q.push_back('{int'(req_x), int'(req_y), int'(req_colour), int'(req_size)});
        end
        cyc++;
    endtask

    task automatic cycle();
        check_outputs();
        model_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input bit v, input int x, input int y, input int c, input int s);
        req_valid  = v;
        req_x      = 8'(x);
        req_y      = 7'(y);
        req_colour = 3'(c);
        req_size   = 4'(s);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        repeat (n) cycle();
    endtask

    // Hold a request until accepted, bounded.
    task automatic push(input int x, input int y, input int c, input int s);
        bit done = 0;
        drive(1, x, y, c, s);
        for (int k = 0; k < 600 && !done; k++) begin
            done = req_ready;
            cycle();
        end
        req_valid = 0;
        chk("push_accepted", 32'(done), 1);
    endtask

    // Count drawer_resetn-high cycles over a window.
    task automatic count_high(input int n, output int hi);
        hi = 0;
        drive(0, 0, 0, 0, 0);
        repeat (n) begin
            if (drawer_resetn === 1'b1) hi++;
            cycle();
        end
    endtask

    int hi;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge clock);
        @(negedge clock);
        model_reset();
        cyc = 1;
        chk("reset_ready", req_ready, 1);
        chk("reset_resetn", drawer_resetn, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        idle(2);

        // Single request: 27 draw cycles, busy clears at T+30.
        push(10, 20, 4, 4);
        chk("latch_x_after_pop", start_x, 0);
        cycle();
        chk("latched_x", start_x, 10);
        chk("latched_y", start_y, 20);
        chk("restart_low", drawer_resetn, 0);
        count_high(40, hi);
        chk("draw_len_size4", hi, 27);

        // Fill the FIFO while the first request draws; the fifth waits for a pop.
        push(30, 40, 1, 3);
        idle(3);
        push(1, 2, 2, 1);
        push(3, 4, 3, 2);
        push(5, 6, 5, 1);
        push(7, 8, 6, 2);
        chk("ready_full", req_ready, 0);
        push(9, 10, 7, 1);
        idle(150);

        // Clamping at the frame edge.
        push(158, 118, 2, 5);
        idle(3);
        chk("clamp_x", start_x, 155);
        chk("clamp_y", start_y, 115);
        idle(45);

        // Zero-size discard, then a size-1 draw with a 6-cycle budget.
        push(0, 0, 0, 0);
        push(1, 1, 1, 1);
        count_high(20, hi);
        chk("draw_len_size1", hi, 6);

        // Largest block.
        push(50, 50, 3, 15);
        count_high(270, hi);
        chk("draw_len_size15", hi, 258);

        // Reset mid-draw with two entries still queued.
        push(10, 10, 1, 3);
        push(20, 20, 2, 3);
        push(30, 30, 3, 3);
        idle(2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_reset_resetn", drawer_resetn, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_ready", req_ready, 1);
        count_high(60, hi);
        chk("no_draw_after_reset", hi, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 255), $urandom_range(0, 127),
                  $urandom_range(0, 7),
                  ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 4));
            cycle();
        end
        reset = 1'b0;
        idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
